// File: rtl/classifier_pkg.sv
// Shared class encoding and sizing helpers for the multi-channel event classifier.
package classifier_pkg;

  typedef enum logic [1:0] {
    CLS_C = 2'b00,
    CLS_B = 2'b01,
    CLS_A = 2'b10
  } cls_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/classifier_mc_if.sv
// Change-report handshake: one channel/class pair per valid/ready transfer.
interface classifier_mc_if #(
  parameter int CH_W = 2
) ();

  logic            rpt_valid;
  logic            rpt_ready;
  logic [CH_W-1:0] rpt_ch;
  logic [1:0]      rpt_class;

  modport master (output rpt_valid, output rpt_ch, output rpt_class, input rpt_ready);
  modport slave  (input rpt_valid, input rpt_ch, input rpt_class, output rpt_ready);

endinterface

// File: rtl/classifier_channel.sv
// One channel: leaky saturating excitability score plus the C/B/A class FSM
// with confirmed promotion and quiet-time demotion.
//
// state | meaning
// CLS_C | quiescent, score below b_thresh (or timed out of B)
// CLS_B | elevated, promoted after CONFIRM_N samples above C
// CLS_A | active, left only after refractory quiet samples
module classifier_channel
  import classifier_pkg::*;
#(
  parameter int EXC_W     = 12,
  parameter int TIME_W    = 16,
  parameter int EXC_INC   = 100,
  parameter int EXC_DEC   = 100,
  parameter int EXC_MAX   = 1000,
  parameter int CONFIRM_N = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic              det,
  input  logic [EXC_W-1:0]  a_thresh,
  input  logic [EXC_W-1:0]  b_thresh,
  input  logic [TIME_W-1:0] decay_period,
  input  logic [TIME_W-1:0] timeout,
  input  logic [TIME_W-1:0] refractory,
  output cls_t              cls,
  output logic              changed
);

  localparam int CNF_W = (CONFIRM_N > 1) ? $clog2(CONFIRM_N) : 1;
  localparam logic [CNF_W-1:0] CNF_LAST = CNF_W'(CONFIRM_N - 1);

  cls_t              cls_q, cls_nxt, cand;
  logic [CNF_W-1:0]  cnf_q, cnf_nxt;
  logic [EXC_W-1:0]  exc_q, exc_nxt;
  logic [TIME_W-1:0] quiet_q, quiet_nxt;
  logic [TIME_W-1:0] decay_q, decay_nxt;
  logic [31:0]       exc_sum;
  logic              decay_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_q   <= CLS_C;
      cnf_q   <= '0;
      exc_q   <= '0;
      quiet_q <= '0;
      decay_q <= '0;
    end else begin
      cls_q   <= cls_nxt;
      cnf_q   <= cnf_nxt;
      exc_q   <= exc_nxt;
      quiet_q <= quiet_nxt;
      decay_q <= decay_nxt;
    end
  end

  // Score path: 32-bit sum so EXC_INC near the ceiling cannot wrap before the clamp.
  assign exc_sum   = 32'(exc_q) + 32'(EXC_INC);
  assign decay_hit = ({1'b0, decay_q} + (TIME_W+1)'(1)) == {1'b0, decay_period};

  always_comb begin
    exc_nxt   = exc_q;
    quiet_nxt = quiet_q;
    decay_nxt = decay_q;
    if (sample_en) begin
      if (det) begin
        exc_nxt   = (exc_sum > 32'(EXC_MAX)) ? EXC_W'(EXC_MAX) : exc_sum[EXC_W-1:0];
        quiet_nxt = '0;
        decay_nxt = '0;
      end else begin
        if (quiet_q != '1) quiet_nxt = quiet_q + TIME_W'(1);
        if (decay_period != '0) begin
          if (decay_hit) begin
            exc_nxt   = (32'(exc_q) > 32'(EXC_DEC)) ? exc_q - EXC_W'(EXC_DEC) : '0;
            decay_nxt = '0;
          end else begin
            decay_nxt = decay_q + TIME_W'(1);
          end
        end
      end
    end
  end

  // Candidate uses the registered score, so class lags the score by one sample.
  always_comb begin
    if (exc_q >= a_thresh)      cand = CLS_A;
    else if (exc_q >= b_thresh) cand = CLS_B;
    else                        cand = CLS_C;
  end

  always_comb begin
    cls_nxt = cls_q;
    cnf_nxt = cnf_q;
    if (sample_en) begin
      if (cand > cls_q) begin
        if (cnf_q == CNF_LAST) begin
          cls_nxt = cand;
          cnf_nxt = '0;
        end else begin
          cnf_nxt = cnf_q + CNF_W'(1);
        end
      end else begin
        cnf_nxt = '0;
        unique case (cls_q)
          CLS_A: if (cand != CLS_A && quiet_q >= refractory) cls_nxt = cand;
          CLS_B: if (cand == CLS_C && quiet_q >= timeout)    cls_nxt = CLS_C;
          default: cls_nxt = cls_q;
        endcase
      end
    end
  end

  assign cls     = cls_q;
  assign changed = (cls_nxt != cls_q);

endmodule

// File: rtl/classifier_mc.sv
// Multi-channel classifier: per-channel class FSMs, coalescing pending bits and a
// round-robin arbiter feeding a single registered change-report port.
module classifier_mc
  import classifier_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int EXC_W     = 12,
  parameter int TIME_W    = 16,
  parameter int EXC_INC   = 100,
  parameter int EXC_DEC   = 100,
  parameter int EXC_MAX   = 1000,
  parameter int CONFIRM_N = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_en,
  input  logic [NUM_CH-1:0]   det,
  input  logic [EXC_W-1:0]    a_thresh,
  input  logic [EXC_W-1:0]    b_thresh,
  input  logic [TIME_W-1:0]   decay_period,
  input  logic [TIME_W-1:0]   timeout,
  input  logic [TIME_W-1:0]   refractory,
  output logic [2*NUM_CH-1:0] class_out,
  classifier_mc_if.master     rpt
);

  localparam int CH_W = ch_width(NUM_CH);

  cls_t              cls_ch [NUM_CH];
  logic [NUM_CH-1:0] changed;
  logic [NUM_CH-1:0] pending_q, pending_nxt;
  logic [CH_W-1:0]   last_q, grant, idx_c;
  logic              found, load;
  logic              rpt_valid_q;
  logic [CH_W-1:0]   rpt_ch_q;
  cls_t              rpt_class_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    classifier_channel #(
      .EXC_W     (EXC_W),
      .TIME_W    (TIME_W),
      .EXC_INC   (EXC_INC),
      .EXC_DEC   (EXC_DEC),
      .EXC_MAX   (EXC_MAX),
      .CONFIRM_N (CONFIRM_N)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_en    (sample_en),
      .det          (det[i]),
      .a_thresh     (a_thresh),
      .b_thresh     (b_thresh),
      .decay_period (decay_period),
      .timeout      (timeout),
      .refractory   (refractory),
      .cls          (cls_ch[i]),
      .changed      (changed[i])
    );
    assign class_out[2*i +: 2] = cls_ch[i];
  end

  // Scan starts one past the last grant so no channel can starve the others.
  always_comb begin
    found = 1'b0;
    grant = last_q;
    idx_c = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx_c = CH_W'((int'(last_q) + k) % NUM_CH);
      if (!found && pending_q[idx_c]) begin
        found = 1'b1;
        grant = idx_c;
      end
    end
  end

  assign load = !rpt_valid_q || rpt.rpt_ready;

  // A change on the grant edge re-arms the bit, so the newer class is reported later.
  always_comb begin
    pending_nxt = pending_q;
    if (load && found) pending_nxt[grant] = 1'b0;
    pending_nxt = pending_nxt | changed;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      last_q      <= CH_W'(NUM_CH - 1);
      rpt_valid_q <= 1'b0;
      rpt_ch_q    <= '0;
      rpt_class_q <= CLS_C;
    end else begin
      pending_q <= pending_nxt;
      if (load) begin
        if (found) begin
          rpt_valid_q <= 1'b1;
          rpt_ch_q    <= grant;
          rpt_class_q <= cls_ch[grant];
          last_q      <= grant;
        end else begin
          rpt_valid_q <= 1'b0;
        end
      end
    end
  end

  assign rpt.rpt_valid = rpt_valid_q;
  assign rpt.rpt_ch    = rpt_ch_q;
  assign rpt.rpt_class = rpt_class_q;

endmodule

// File: doc/classifier_mc.md
# classifier_mc

Parametrised multi-channel successor to the single-channel event classifier. Each of `NUM_CH` channels integrates its own detection pulses into a saturating, linearly leaking excitability score and classifies it into C/B/A. Promotion requires confirmation, and demotion uses timeout/refractory hysteresis. Class changes are queued per channel and reported one at a time over a valid/ready port by a round-robin arbiter, so the downstream logger sees every channel's transitions.

## Interface
Parameters:
- `NUM_CH`, 4: channel count (≥1); `CH_W = max(1, $clog2(NUM_CH))`.
- `EXC_W`, 12: excitability width.
- `TIME_W`, 16: sample-counter and period width.
- `EXC_INC`, 100: added per detection.
- `EXC_DEC`, 100: subtracted per decay step.
- `EXC_MAX`, 1000: saturation ceiling. Must satisfy `EXC_MAX < 2**EXC_W`.
- `CONFIRM_N`, 5: consecutive samples needed for promotion (≥1).

Ports:
- `clk`  in  1: single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `sample_en`  in  1: sample tick; all channel state advances only on cycles where it is high.
- `det`  in  NUM_CH: per-channel detection, sampled when `sample_en` is high.
- `a_thresh`, `b_thresh`  in  EXC_W: class thresholds, shared by all channels; unsigned.
- `decay_period`  in  TIME_W: samples per decay step; 0 disables decay.
- `timeout`  in  TIME_W: quiet samples before B→C.
- `refractory`  in  TIME_W: quiet samples before leaving A.
- `class_out`  out  2*NUM_CH: current class per channel; channel i is at bits [2i+1:2i].
- `rpt_valid`  out  1: a change report is available.
- `rpt_ready`  in  1: downstream accepts the report.
- `rpt_ch`  out  CH_W: channel of the report.
- `rpt_class`  out  2: class of the report.

## Operation
- Encoding: C=2'b00, B=2'b01, A=2'b10. 2'b11 is never produced.
- Per channel, on each `sample_en` cycle:
  - Detection sets `exc <= min(exc+EXC_INC, EXC_MAX)` and clears `quiet_cnt` and `decay_cnt`.
  - No detection:
    - `quiet_cnt` increments, saturating at all-ones.
    - If `decay_period != 0`, `decay_cnt` increments.
    - When `decay_cnt+1 == decay_period`: `exc <= exc - min(exc, EXC_DEC)` and `decay_cnt <= 0`.
  - Candidate class, computed from the registered `exc` before this sample's update: A if `exc >= a_thresh`, else B if `exc >= b_thresh`, else C.
  - Candidate > class: `confirm_cnt++`. When `confirm_cnt == CONFIRM_N-1`, class takes the candidate (C→A may be direct) and `confirm_cnt` clears.
  - Candidate ≤ class: `confirm_cnt` clears.
  - Class A, candidate < A, and `quiet_cnt >= refractory`: class takes the candidate.
  - Class B, candidate C, and `quiet_cnt >= timeout`: class becomes C.
  - Promotion and demotion are mutually exclusive by construction.
- Any class change sets the channel's `pending` bit on the same edge.
- Report port:
  - Output register loads when `!rpt_valid || rpt_ready`.
  - It picks the first pending channel, scanning round-robin starting one after the last granted channel.
  - Load: `rpt_ch <= i`, `rpt_class <=` channel i's current class, `rpt_valid <= 1`, and `pending[i]` clears.
  - With no pending channel, `rpt_valid` drops after the handshake completes.
  - Multiple changes before service coalesce; the report carries the latest class.
  - If channel i changes on the same edge it is granted, the set wins and `pending[i]` stays 1.
- Payload is held stable while `rpt_valid && !rpt_ready`.

## Timing
- Reset (asynchronous assert, synchronous release): all `exc`, `quiet_cnt`, `decay_cnt`, `confirm_cnt`, and `pending` are 0.
- Reset values of outputs: `class_out = 0` (all channels C), `rpt_valid = 0`, `rpt_ch = 0`, `rpt_class = 0`. The round-robin pointer starts so that channel 0 is checked first.
- `exc` updates on the clock edge that samples the `sample_en` cycle.
- Class is evaluated from pre-update `exc`, so it lags `exc` by one sample.
- Class change → `pending` on the same edge → `rpt_valid` earliest on the next edge.
- Back-to-back reports: one per cycle while `rpt_ready` is held high.
- Threshold or period inputs may change at any time and take effect at the next `sample_en`. There is no reprogramming sequence.
- `rst_n` low mid-report drops `rpt_valid` immediately and discards all pending bits.

## Structure
- Package `classifier_pkg`: class encodings `CLS_C`/`CLS_B`/`CLS_A` and a `cls_t` 2-bit typedef.
- Sub-module `classifier_channel`:
  - Holds one channel's `exc` and counters plus the class FSM.
  - Outputs `cls` and a one-cycle `changed` strobe.
  - Instantiated `NUM_CH` times via generate.
- Top level `classifier_mc` contains the pending bits, the round-robin arbiter, and the report register.

## Test plan
- Defaults; `a_thresh=500`, `b_thresh=100`; `sample_en` every cycle; 5 consecutive `det[0]` → `exc` reaches 500. Class goes C→B after 5 samples with candidate ≥B, then to A after 5 samples at candidate A. Reports (0,B) then (0,A).
- `det[1]` held high for 20 samples → `exc` saturates at 1000 and does not wrap. `class_out[3:2]=A`.
- Channel 0 in A, `decay_period=4`, `refractory=40`, no detections → `exc` drops by 100 every 4 samples. Class leaves A only at `quiet_cnt=40`, to the then-current candidate; then B→C at `quiet_cnt >= timeout`.
- Candidate B lasting 4 samples, then 1 sample of candidate C, with `CONFIRM_N=5` → no promotion and no report.
- All 4 channels change class on the same edge, `rpt_ready=0` for 10 cycles then 1 → payload stable while stalled. Reports then follow in order ch0, ch1, ch2, ch3 on consecutive cycles; next grant starts at ch0.
- `rst_n` pulsed low while `rpt_valid=1` with 2 channels pending → `rpt_valid=0` and `class_out=0` asynchronously. No stale reports after release.
